// File: rtl/swt16_defs.sv
// swt16_defs: shared swt16 definitions (loader state encoding, byte width)
package swt16_defs;
    localparam int BYTE_WIDTH = 8;
    typedef enum logic [3:0] {
        IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK, DONE, ERROR
    } state_t;
endpackage

// File: rtl/pmem_loader.sv
// pmem_loader: byte-stream program-memory loader holding the core until the image is in.
// Define PMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module pmem_loader
    import swt16_defs::*;
#(
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int PMEM_NUM_WORDS  = 2048,
    parameter int PC_INCREMENT    = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_start,
    input  logic [BYTE_WIDTH-1:0]      in_byte,
    input  logic                       in_byte_valid,
    output logic                       out_byte_ready,
    output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
    output logic [PMEM_WORD_WIDTH-1:0] out_pmem_word,
    output logic                       out_pmem_write_en,
    output logic                       out_cpu_hold,
    output logic                       out_done,
    output logic                       out_error,
    output logic [PMEM_ADDR_WIDTH-1:0] out_words_loaded
);
`ifdef PMEM_LOADER_CHECKSUM_EN
    localparam state_t FIN = CHECK;
    logic [BYTE_WIDTH-1:0] csum;
`else
    localparam state_t FIN = DONE;
`endif
    state_t                state;
    logic [BYTE_WIDTH-1:0] lo;
    logic [15:0]           left;
    logic [15:0]           pair;
    logic                  acc;
    assign pair = {in_byte, lo};
    assign out_byte_ready = state inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK};
    assign acc = in_byte_valid && out_byte_ready;
    assign out_pmem_write_en = state == WRITE;
    assign out_cpu_hold = state != DONE;
    assign out_done = state == DONE;
    assign out_error = state == ERROR;
    // lo captures every accepted byte; it holds the low half whenever a high byte arrives
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            lo <= '0;
            left <= '0;
            out_pmem_addr <= '0;
            out_pmem_word <= '0;
            out_words_loaded <= '0;
`ifdef PMEM_LOADER_CHECKSUM_EN
            csum <= '0;
`endif
        end else begin
            if (acc) lo <= in_byte;
`ifdef PMEM_LOADER_CHECKSUM_EN
            if (acc) csum <= csum ^ in_byte;
`endif
            case (state)
                IDLE, DONE, ERROR: if (in_start) begin
                    state <= LEN_LO;
                    out_pmem_addr <= '0;
                    out_words_loaded <= '0;
`ifdef PMEM_LOADER_CHECKSUM_EN
                    csum <= '0;
`endif
                end
                LEN_LO: if (acc) state <= LEN_HI;
                LEN_HI: if (acc) begin
                    left <= pair;
                    state <= (pair == 16'd0) ? FIN : (pair > 16'(PMEM_NUM_WORDS)) ? ERROR : DATA_LO;
                end
                DATA_LO: if (acc) state <= DATA_HI;
                DATA_HI: if (acc) begin
                    out_pmem_word <= pair;
                    state <= WRITE;
                end
                WRITE: begin
                    out_pmem_addr <= out_pmem_addr + PMEM_ADDR_WIDTH'(PC_INCREMENT);
                    out_words_loaded <= out_words_loaded + PMEM_ADDR_WIDTH'(1);
                    left <= left - 16'd1;
                    state <= (left == 16'd1) ? FIN : DATA_LO;
                end
`ifdef PMEM_LOADER_CHECKSUM_EN
                CHECK: if (acc) state <= (in_byte == csum) ? DONE : ERROR;
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmem_loader.sv
// tb_pmem_loader: table-driven image loads plus reset, mid-load start and reload sequences.
module tb_pmem_loader;
    logic        clock = 0, reset = 0, in_start = 0, in_byte_valid = 0;
    logic [7:0]  in_byte = 0;
    logic        out_byte_ready, out_pmem_write_en, out_cpu_hold, out_done, out_error;
    logic [11:0] out_pmem_addr, out_words_loaded;
    logic [15:0] out_pmem_word;

    pmem_loader dut (
        .clock(clock), .reset(reset), .in_start(in_start), .in_byte(in_byte),
        .in_byte_valid(in_byte_valid), .out_byte_ready(out_byte_ready),
        .out_pmem_addr(out_pmem_addr), .out_pmem_word(out_pmem_word),
        .out_pmem_write_en(out_pmem_write_en), .out_cpu_hold(out_cpu_hold),
        .out_done(out_done), .out_error(out_error), .out_words_loaded(out_words_loaded)
    );

    always #5 clock = ~clock;

    int passed = 0, total = 0;
    logic [11:0] wa[$];
    logic [15:0] wd[$];
    bit rdy_bad = 0, pulse_bad = 0, both_bad = 0, prev_we = 0;

    always @(negedge clock) begin
        if (out_pmem_write_en) begin
            wa.push_back(out_pmem_addr);
            wd.push_back(out_pmem_word);
            if (out_byte_ready) rdy_bad = 1;
            if (prev_we) pulse_bad = 1;
        end
        if (out_done && out_error) both_bad = 1;
        prev_we = out_pmem_write_en;
    end

    typedef struct {
        logic [15:0] n;
        logic [15:0] w[3];
        bit rnd, bad, exp_done, exp_err;
        int exp_wr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [15:0] n, logic [15:0] w0, w1, w2, bit rnd, bad, d, e, int wr);
        vec_t v;
        v.n = n; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
        v.rnd = rnd; v.bad = bad; v.exp_done = d; v.exp_err = e; v.exp_wr = wr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_byte_valid = 0;
        repeat (gap) @(negedge clock);
        in_byte = b;
        in_byte_valid = 1;
        for (int t = 0; t < 20 && !out_byte_ready; t++) @(negedge clock);
        if (!out_byte_ready) begin
            total++;
            $display("FAIL ready_timeout: byte %0h never accepted", b);
        end
        @(negedge clock);
        in_byte_valid = 0;
    endtask

    task automatic pulse_start();
        in_start = 1;
        @(negedge clock);
        in_start = 0;
    endtask

    task automatic load(input vec_t v);
        logic [7:0] x;
        int g;
        wa.delete();
        wd.delete();
        pulse_start();
        chk("ready_after_start", out_byte_ready, 1);
        g = v.rnd ? int'($urandom_range(0, 3)) : 0;
        send_byte(v.n[7:0], g);
        g = v.rnd ? int'($urandom_range(0, 3)) : 0;
        send_byte(v.n[15:8], g);
        x = v.n[7:0] ^ v.n[15:8];
        if (v.n <= 16'd3)
            for (int i = 0; i < int'(v.n); i++) begin
                g = v.rnd ? int'($urandom_range(0, 3)) : 0;
                send_byte(v.w[i][7:0], g);
                g = v.rnd ? int'($urandom_range(0, 3)) : 0;
                send_byte(v.w[i][15:8], g);
                x = x ^ v.w[i][7:0] ^ v.w[i][15:8];
            end
`ifdef PMEM_LOADER_CHECKSUM_EN
        if (v.n <= 16'd2048) send_byte(v.bad ? ~x : x, 0);
`else
        if (v.n != 16'd0 && v.n <= 16'd2048) begin
            chk("we_after_last_byte", out_pmem_write_en, 1);
            chk("done_during_write", out_done, 0);
            @(negedge clock);
        end
`endif
        chk("done", out_done, v.exp_done);
        chk("error", out_error, v.exp_err);
        chk("hold", out_cpu_hold, !v.exp_done);
        chk("words_loaded", out_words_loaded, v.exp_wr);
        chk("write_count", wa.size(), v.exp_wr);
        for (int i = 0; i < v.exp_wr && i < wa.size(); i++) begin
            chk("write_addr", wa[i], 2 * i);
            chk("write_word", wd[i], v.w[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back(mk(16'd3, 16'h1234, 16'hABCD, 16'h0001, 0, 0, 1, 0, 3));
        vecs.push_back(mk(16'd3, 16'h1234, 16'hABCD, 16'h0001, 1, 0, 1, 0, 3));
        vecs.push_back(mk(16'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 0));
        vecs.push_back(mk(16'd2049, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0));
        vecs.push_back(mk(16'd1, 16'h00FF, 16'h0000, 16'h0000, 0, 0, 1, 0, 1));
        vecs.push_back(mk(16'd2, 16'hFFFF, 16'h8000, 16'h0000, 1, 0, 1, 0, 2));
`ifdef PMEM_LOADER_CHECKSUM_EN
        vecs.push_back(mk(16'd1, 16'h00FF, 16'h0000, 16'h0000, 0, 1, 0, 1, 1));
`endif
        repeat (3) @(negedge clock);
        chk("rst_ready", out_byte_ready, 0);
        chk("rst_we", out_pmem_write_en, 0);
        chk("rst_addr", out_pmem_addr, 0);
        chk("rst_word", out_pmem_word, 0);
        chk("rst_hold", out_cpu_hold, 1);
        chk("rst_done", out_done, 0);
        chk("rst_error", out_error, 0);
        chk("rst_words", out_words_loaded, 0);
        reset = 1;
        @(negedge clock);

        foreach (vecs[i]) load(vecs[i]);

        // reset right after the second word's write cycle
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        send_byte(8'hCD, 0);
        send_byte(8'hAB, 0);
        reset = 0;
        @(negedge clock);
        chk("mid_rst_ready", out_byte_ready, 0);
        chk("mid_rst_we", out_pmem_write_en, 0);
        chk("mid_rst_addr", out_pmem_addr, 0);
        chk("mid_rst_word", out_pmem_word, 0);
        chk("mid_rst_hold", out_cpu_hold, 1);
        chk("mid_rst_done", out_done, 0);
        chk("mid_rst_error", out_error, 0);
        chk("mid_rst_words", out_words_loaded, 0);
        chk("mid_rst_writes", wa.size(), 2);
        reset = 1;
        @(negedge clock);
        load(vecs[0]);

        // start during a load is ignored
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        pulse_start();
        chk("ignored_start_ready", out_byte_ready, 1);
        send_byte(8'h11, 0);
        pulse_start();
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
`ifdef PMEM_LOADER_CHECKSUM_EN
        send_byte(8'h02 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 0);
`else
        @(negedge clock);
`endif
        chk("ignored_start_done", out_done, 1);
        chk("ignored_start_writes", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("ignored_start_addr1", wa[1], 2);
            chk("ignored_start_word0", wd[0], 16'h2211);
            chk("ignored_start_word1", wd[1], 16'h4433);
        end

        // start after done re-holds the core and a second image loads
        pulse_start();
        chk("restart_hold", out_cpu_hold, 1);
        chk("restart_done", out_done, 0);
        chk("restart_ready", out_byte_ready, 1);
        load(vecs[1]);

        chk("ready_low_in_write", rdy_bad, 0);
        chk("write_single_cycle", pulse_bad, 0);
        chk("done_error_exclusive", both_bad, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pmem_loader.md
# pmem_loader

Program-memory loader for the swt16 core: the write-side counterpart of the fetch stage's program-memory read port. It accepts a byte stream over a valid/ready handshake and assembles little-endian 16-bit instruction words. It writes those words into the program memory at consecutive PC addresses and holds the core in reset until the image is complete. It sits beside `pmem_sim` in the top level and drives its write port plus the core's hold signal.

## Interface
- `PMEM_ADDR_WIDTH`, 12, width of program-memory address (byte address, same as PC)
- `PMEM_WORD_WIDTH`, 16, instruction word width; fixed at 16 (two bytes per word)
- `PMEM_NUM_WORDS`, 2048, capacity; larger images are rejected
- `PC_INCREMENT`, 2, address step per written word
- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `in_start`  in  1  one-cycle pulse: begin a new load
- `in_byte`  in  8  stream data byte
- `in_byte_valid`  in  1  `in_byte` is valid
- `out_byte_ready`  out  1  loader accepts a byte this cycle
- `out_pmem_addr`  out  PMEM_ADDR_WIDTH  write address
- `out_pmem_word`  out  PMEM_WORD_WIDTH  write data
- `out_pmem_write_en`  out  1  one-cycle write strobe
- `out_cpu_hold`  out  1  core must be held in reset while high
- `out_done`  out  1  image loaded successfully (level)
- `out_error`  out  1  load aborted (level)
- `out_words_loaded`  out  PMEM_ADDR_WIDTH  count of words written in the current load

## Operation
- Stream format: LEN_LO, LEN_HI (word count N, 16-bit), then N × {DATA_LO, DATA_HI}. Checksum byte follows when enabled.
- States:
  - IDLE → LEN_LO on `in_start`.
  - LEN_LO → LEN_HI on byte accept.
  - LEN_HI → DATA_LO if 0 < N ≤ PMEM_NUM_WORDS; → DONE (or CHECK) if N = 0; → ERROR if N > PMEM_NUM_WORDS.
  - DATA_LO → DATA_HI on byte accept.
  - DATA_HI → WRITE on byte accept.
  - WRITE → DATA_LO if words remain, else → DONE (or CHECK).
  - CHECK → DONE or ERROR.
  - DONE / ERROR → LEN_LO on `in_start`.
- A byte is accepted only when `in_byte_valid && out_byte_ready`.
- `out_byte_ready` is high only in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHECK. It is low in IDLE, WRITE, DONE and ERROR.
- Address starts at 0 and increments by PC_INCREMENT after each write. It wraps modulo 2^PMEM_ADDR_WIDTH; the N bound makes wrap unreachable at default parameters.
- `out_cpu_hold` = 1 in every state except DONE.
- `in_start` is ignored in LEN_LO through CHECK, i.e. while a load is in progress.
- `out_done` and `out_error` are never high together.

## Timing
- Reset (`reset`=0 at a clock edge) puts the loader in IDLE with these output values: ready 0, write_en 0, addr 0, word 0, hold 1, done 0, error 0, words_loaded 0. This applies mid-load as well; the partial image is left in memory.
- `in_start` at edge k: `out_byte_ready`=1 from cycle k+1, and address, word count and checksum are cleared.
- DATA_HI byte accepted at edge k: in cycle k+1, write_en=1 with addr/word valid for exactly that cycle, and ready=0. `words_loaded` increments at edge k+2.
- Maximum throughput is 2 bytes per 3 cycles.
- Final write (or CHECK success) at edge k: `out_done`=1 and `out_cpu_hold`=0 from cycle k+1.

## Configuration
- `PMEM_LOADER_CHECKSUM_EN` defined:
  - A running XOR is kept over every accepted byte, including the length bytes.
  - CHECK state follows the last word (or LEN_HI when N = 0) and accepts one byte.
  - Match → DONE. Mismatch → ERROR with hold kept high. Words already written stay in memory.
- Not defined: CHECK state and the XOR register are absent; the last write goes directly to DONE.

## Structure
- Shared header/package `swt16_defs` holds:
  - state encoding localparams (IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK, DONE, ERROR; 4 bits)
  - BYTE_WIDTH = 8
- Single module; no sub-module is needed. The byte-pair assembler is a 8-bit low-byte register inside the FSM.
- `pmem_sim` gains a write port (`in_write_en`, `in_addr_wr`, `in_word`), matching `dmem_sim`.

## Test plan
- Load N=3 words 0x1234, 0xABCD, 0x0001, valid held high → writes at addr 0, 2, 4 with those words. Each write_en is a 1-cycle pulse; done=1 and hold=0 one cycle after the third write; words_loaded=3.
- Valid toggled randomly with 0–3 idle cycles between bytes → identical writes. No byte is lost or duplicated; ready is low in every WRITE cycle.
- N=0 → done one cycle after LEN_HI accept, with no write_en. N=2049 → error=1, hold=1, no writes.
- Reset low after the 2nd word is written → all outputs at reset values next cycle. A following `in_start` plus a fresh image loads from addr 0.
- `PMEM_LOADER_CHECKSUM_EN`, N=1, word 0x00FF, correct XOR 0xFE (0x01^0x00^0xFF^0x00) → done. Checksum byte 0x00 instead → error=1, hold=1.
- `in_start` pulsed mid-load → ignored. `in_start` after done → hold rises next cycle and a second image loads.
